// File: rtl/read_buffer_if.sv
// Read-response and pixel-stream signals between the SDRAM read master,
// the read_buffer, and the filter pipeline.
interface read_buffer_if #(
    parameter int PIXEL_W = 24,
    parameter int DATA_W  = 32
);
    logic               master_readdatavalid;
    logic [DATA_W-1:0]  master_readdata;
    logic               pixel_ready;
    logic [PIXEL_W-1:0] pixel_out;
    logic               pixel_valid;
    logic               fill_ready;
    logic               done_read;
    logic               overflow;

    // Side that issues reads and consumes pixels.
    modport master (
        output master_readdatavalid,
        output master_readdata,
        output pixel_ready,
        input  pixel_out,
        input  pixel_valid,
        input  fill_ready,
        input  done_read,
        input  overflow
    );

    // The buffer itself.
    modport slave (
        input  master_readdatavalid,
        input  master_readdata,
        input  pixel_ready,
        output pixel_out,
        output pixel_valid,
        output fill_ready,
        output done_read,
        output overflow
    );
endinterface

// File: rtl/read_buffer.sv
// Two-bank ping-pong store for SDRAM read bursts. One bank fills from
// readdata while the other drains one pixel per accepted handshake.
//
// bank state | meaning
// -----------+---------------------------------------------------------
// ST_EMPTY   | no data, writable
// ST_FILLING | first word(s) of a burst written, still writable
// ST_FULL    | all BURST_LEN words present; draining when drain_sel points here
module read_buffer #(
    parameter int BURST_LEN = 6,
    parameter int PIXEL_W   = 24,
    parameter int DATA_W    = 32
) (
    input  logic         clk,
    input  logic         rst,
    read_buffer_if.slave bus
);
    localparam int              CNT_W = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FILLING,
        ST_FULL
    } bank_state_t;

    bank_state_t        bank_st [2];
    logic [PIXEL_W-1:0] mem     [2][BURST_LEN];
    logic               fill_sel;
    logic               drain_sel;
    logic [CNT_W-1:0]   fill_cnt;
    logic [CNT_W-1:0]   drain_cnt;
    logic               done_read_q;
    logic               overflow_q;

    logic fill_full;
    logic drain_full;
    logic wr_en;
    logic acc;

    // A bank being drained stays FULL until its last pixel is accepted, so a
    // word aimed at it in that same cycle is an overflow, not a write.
    assign fill_full  = (bank_st[fill_sel] == ST_FULL);
    assign drain_full = (bank_st[drain_sel] == ST_FULL);
    assign wr_en      = bus.master_readdatavalid && !fill_full;
    assign acc        = drain_full && bus.pixel_ready;

    assign bus.fill_ready  = !fill_full;
    assign bus.pixel_valid = drain_full;
    assign bus.pixel_out   = mem[drain_sel][drain_cnt];
    assign bus.done_read   = done_read_q;
    assign bus.overflow    = overflow_q;

    generate
        if (DATA_W > PIXEL_W) begin : g_drop_hi
            logic unused_hi;
            assign unused_hi = ^bus.master_readdata[DATA_W-1:PIXEL_W];
        end
    endgenerate

    // Bank state, fill/drain pointers and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_st[0]  <= ST_EMPTY;
            bank_st[1]  <= ST_EMPTY;
            fill_sel    <= 1'b0;
            drain_sel   <= 1'b0;
            fill_cnt    <= '0;
            drain_cnt   <= '0;
            done_read_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            done_read_q <= 1'b0;
            if (bus.master_readdatavalid && fill_full) begin
                overflow_q <= 1'b1;
            end
            // Fill and drain never touch the same bank in one cycle: the
            // fill bank is writable only when not FULL, the drain bank only
            // advances when FULL.
            if (wr_en) begin
                if (fill_cnt == LAST) begin
                    bank_st[fill_sel] <= ST_FULL;
                    fill_cnt          <= '0;
                    fill_sel          <= ~fill_sel;
                    done_read_q       <= 1'b1;
                end else begin
                    bank_st[fill_sel] <= ST_FILLING;
                    fill_cnt          <= fill_cnt + 1'b1;
                end
            end
            if (acc) begin
                if (drain_cnt == LAST) begin
                    bank_st[drain_sel] <= ST_EMPTY;
                    drain_cnt          <= '0;
                    drain_sel          <= ~drain_sel;
                end else begin
                    drain_cnt <= drain_cnt + 1'b1;
                end
            end
        end
    end

    // Pixel storage; only the low PIXEL_W bits of each word are kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int s = 0; s < BURST_LEN; s++) begin
                    mem[b][s] <= '0;
                end
            end
        end else if (wr_en) begin
            mem[fill_sel][fill_cnt] <= bus.master_readdata[PIXEL_W-1:0];
        end
    end
endmodule

// File: tb/tb_read_buffer.sv
// Bench for read_buffer: a queue-level model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_read_buffer;
    localparam int BL = 6;
    localparam int PW = 24;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    read_buffer_if #(.PIXEL_W(PW), .DATA_W(DW)) bus ();
    read_buffer #(.BURST_LEN(BL), .PIXEL_W(PW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: complete bursts waiting to drain are a flat pixel queue; the
    // burst still arriving is a separate queue. More than one bank's worth
    // of queued pixels means both banks are FULL.
    logic [PW-1:0] ready_px[$];
    logic [PW-1:0] part[$];
    bit m_done, m_ovf, live;
    bit m_acc, m_wr, m_room;

    always @(posedge clk) begin
        if (rst) begin
            ready_px.delete();
            part.delete();
            m_done = 0;
            m_ovf  = 0;
            live   = 1;
        end else if (live) begin
            m_acc  = bus.pixel_ready && (ready_px.size() > 0);
            m_wr   = bus.master_readdatavalid;
            m_room = ready_px.size() <= BL;
            m_done = 0;
            if (m_acc) void'(ready_px.pop_front());
            if (m_wr) begin
                if (m_room) begin
                    part.push_back(bus.master_readdata[PW-1:0]);
                    if (part.size() == BL) begin
                        foreach (part[i]) ready_px.push_back(part[i]);
                        part.delete();
                        m_done = 1;
                    end
                end else begin
                    m_ovf = 1;
                end
            end
        end
    end

    // Compare process.
    always @(negedge clk) begin
        if (live) begin
            check("pixel_valid", {31'd0, bus.pixel_valid}, {31'd0, ready_px.size() > 0});
            if (ready_px.size() > 0)
                check("pixel_out", {8'd0, bus.pixel_out}, {8'd0, ready_px[0]});
            check("fill_ready", {31'd0, bus.fill_ready}, {31'd0, ready_px.size() <= BL});
            check("done_read", {31'd0, bus.done_read}, {31'd0, m_done});
            check("overflow", {31'd0, bus.overflow}, {31'd0, m_ovf});
        end
    end

    int done_cnt = 0;
    int acc_cnt  = 0;
    always @(negedge clk) begin
        if (bus.done_read) done_cnt++;
        if (bus.pixel_valid && bus.pixel_ready) acc_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [31:0] d);
        bus.master_readdatavalid = v;
        bus.master_readdata      = d;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.master_readdatavalid = 1'b0;
        bus.pixel_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    int d0, sent, budget;

    initial begin
        rst = 1'b1;
        bus.master_readdatavalid = 1'b0;
        bus.master_readdata = '0;
        bus.pixel_ready = 1'b0;
        step();
        step();
        check("rst pixel_valid", {31'd0, bus.pixel_valid}, 32'd0);
        check("rst pixel_out", {8'd0, bus.pixel_out}, 32'd0);
        check("rst fill_ready", {31'd0, bus.fill_ready}, 32'd1);
        check("rst done_read", {31'd0, bus.done_read}, 32'd0);
        check("rst overflow", {31'd0, bus.overflow}, 32'd0);
        rst = 1'b0;

        // 1: single burst, latency and in-order drain
        d0 = done_cnt;
        bus.pixel_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            put(1'b1, i);
            if (i < 6) check("t1 no bypass", {31'd0, bus.pixel_valid}, 32'd0);
        end
        bus.master_readdatavalid = 1'b0;
        check("t1 valid after word6", {31'd0, bus.pixel_valid}, 32'd1);
        check("t1 done pulse", {31'd0, bus.done_read}, 32'd1);
        for (int k = 0; k < 6; k++) begin
            check("t1 pixel", {8'd0, bus.pixel_out}, k + 1);
            step();
        end
        check("t1 drained", {31'd0, bus.pixel_valid}, 32'd0);
        check("t1 done count", done_cnt - d0, 32'd1);

        // 2: both banks full, overflow, gapless drain of 12
        bus.pixel_ready = 1'b0;
        for (int i = 0; i < 12; i++) put(1'b1, 32'h100 + i);
        check("t2 fill_ready low", {31'd0, bus.fill_ready}, 32'd0);
        put(1'b1, 32'h1FF);
        bus.master_readdatavalid = 1'b0;
        check("t2 overflow", {31'd0, bus.overflow}, 32'd1);
        bus.pixel_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            check("t2 valid", {31'd0, bus.pixel_valid}, 32'd1);
            check("t2 pixel", {8'd0, bus.pixel_out}, 32'h100 + k);
            step();
        end
        check("t2 drained", {31'd0, bus.pixel_valid}, 32'd0);
        check("t2 fill_ready back", {31'd0, bus.fill_ready}, 32'd1);

        // 3: upper readdata bits dropped
        do_reset();
        put(1'b1, 32'hFFABCDEF);
        put(1'b1, 32'h12345678);
        for (int i = 0; i < 4; i++) put(1'b1, 32'hEE000000 + i);
        bus.master_readdatavalid = 1'b0;
        check("t3 pixel0", {8'd0, bus.pixel_out}, 32'h00ABCDEF);
        bus.pixel_ready = 1'b1;
        step();
        check("t3 pixel1", {8'd0, bus.pixel_out}, 32'h00345678);
        for (int i = 0; i < 5; i++) step();
        bus.pixel_ready = 1'b0;

        // 5: reset mid-burst discards partial data
        do_reset();
        for (int i = 0; i < 3; i++) put(1'b1, 32'hA1 + i);
        do_reset();
        d0 = done_cnt;
        for (int i = 0; i < 6; i++) put(1'b1, 32'hB1 + i);
        bus.master_readdatavalid = 1'b0;
        bus.pixel_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check("t5 pixel", {8'd0, bus.pixel_out}, 32'hB1 + k);
            step();
        end
        check("t5 drained", {31'd0, bus.pixel_valid}, 32'd0);
        check("t5 done count", done_cnt - d0, 32'd1);
        bus.pixel_ready = 1'b0;

        // 6: drain of bank 0 ends on the edge that fills bank 1
        do_reset();
        for (int i = 0; i < 6; i++) put(1'b1, 32'h600 + i);
        bus.pixel_ready = 1'b1;
        for (int i = 0; i < 5; i++) put(1'b1, 32'h700 + i);
        check("t6 last of bank0", {8'd0, bus.pixel_out}, 32'h605);
        put(1'b1, 32'h705);
        bus.master_readdatavalid = 1'b0;
        check("t6 valid held", {31'd0, bus.pixel_valid}, 32'd1);
        check("t6 bank1 word0", {8'd0, bus.pixel_out}, 32'h700);
        for (int i = 0; i < 6; i++) step();
        bus.pixel_ready = 1'b0;

        // 4: random traffic respecting fill_ready
        do_reset();
        d0 = acc_cnt;
        sent = 0;
        budget = 0;
        while (sent < 600 && budget < 20000) begin
            bus.pixel_ready = 1'($urandom_range(0, 1));
            if (ready_px.size() <= BL && $urandom_range(0, 3) != 0) begin
                put(1'b1, $urandom());
                sent++;
            end else begin
                put(1'b0, $urandom());
            end
            budget++;
        end
        check("t4 words sent", sent, 32'd600);
        bus.master_readdatavalid = 1'b0;
        bus.pixel_ready = 1'b1;
        budget = 0;
        while (ready_px.size() > 0 && budget < 100) begin
            step();
            budget++;
        end
        check("t4 drain finished", {31'd0, ready_px.size() == 0}, 32'd1);
        check("t4 pixels out", acc_cnt - d0, 32'd600);
        check("t4 overflow clear", {31'd0, bus.overflow}, 32'd0);
        bus.pixel_ready = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
